// File: rtl/uart_pkg.sv
// uart_pkg: shared RX state encoding, data width, parity-type constants and majority-vote helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam int DATA_W = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and 3-tap majority vote; in clk/rst/i_rx/i_run/i_start, out o_samp_bit/o_bit_end
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  input  logic i_run,
  input  logic i_start,
  output logic o_samp_bit,
  output logic o_bit_end
);
  localparam int EW = $clog2(OVS);
  localparam logic [EW-1:0] LAST = EW'(OVS - 1);
  localparam logic [EW-1:0] MID = EW'(OVS / 2);
  logic [EW-1:0] r_edge;
  logic r_tap0, r_tap1, r_samp;
  assign o_bit_end = i_run && r_edge == LAST;
  assign o_samp_bit = r_samp;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_edge <= '0;
      r_tap0 <= 1'b0;
      r_tap1 <= 1'b0;
      r_samp <= 1'b0;
    end else begin
      r_edge <= i_start ? EW'(1) : (!i_run || o_bit_end) ? '0 : r_edge + 1'b1;
      if (r_edge == MID - 1'b1) r_tap0 <= i_rx;
      if (r_edge == MID) r_tap1 <= i_rx;
      if (r_edge == MID + 1'b1) r_samp <= maj3(r_tap0, r_tap1, i_rx);
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART RX frame FSM/deserializer; in rx_in/par_en/par_type/parity_error, out samp_bit/p_data/par_chk_en/par_type_q/data_valid/par_err/stop_err/busy
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic              par_type,
  input  logic              parity_error,
  output logic              samp_bit,
  output logic [DATA_W-1:0] p_data,
  output logic              par_chk_en,
  output logic              par_type_q,
  output logic              data_valid,
  output logic              par_err,
  output logic              stop_err,
  output logic              busy
);
  localparam int BW = $clog2(DATA_W);
  rx_state_e r_state, w_next;
  logic [BW-1:0] r_bit_cnt;
  logic [DATA_W-1:0] r_data;
  logic r_par_en, r_par_type, r_dv, r_par_err, r_stop_err;
  logic w_start, w_run, w_bit_end, w_samp;
  assign w_start = r_state == IDLE && !rx_in;
  assign w_run = r_state != IDLE;
  assign samp_bit = w_samp;
  assign p_data = r_data;
  assign par_chk_en = r_state == PARITY && w_bit_end;
  assign par_type_q = r_par_type;
  assign data_valid = r_dv;
  assign par_err = r_par_err;
  assign stop_err = r_stop_err;
  assign busy = w_run;
  uart_rx_sampler #(.OVS(OVS)) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (rx_in),
    .i_run     (w_run),
    .i_start   (w_start),
    .o_samp_bit(w_samp),
    .o_bit_end (w_bit_end)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? START : IDLE;
      START:   w_next = !w_bit_end ? START : w_samp ? IDLE : DATA;
      DATA:    w_next = !(w_bit_end && r_bit_cnt == BW'(DATA_W - 1)) ? DATA : r_par_en ? PARITY : STOP;
      PARITY:  w_next = w_bit_end ? STOP : PARITY;
      STOP:    w_next = w_bit_end ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_dv       <= 1'b0;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_dv <= r_state == STOP && w_bit_end && w_samp && !r_par_err;
      if (w_start) begin
        r_par_en   <= par_en;
        r_par_type <= par_type;
        r_par_err  <= 1'b0;
        r_stop_err <= 1'b0;
      end
      if (r_state == START && w_bit_end) r_bit_cnt <= '0;
      if (r_state == DATA && w_bit_end) begin
        r_data    <= {w_samp, r_data[DATA_W-1:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (par_chk_en) r_par_err <= parity_error;
      if (r_state == STOP && w_bit_end) r_stop_err <= !w_samp;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl with table, corner-case and randomized frames
module tb_uart_rx_ctrl;
  import uart_pkg::*;
  localparam int OVS = 8;
  typedef struct {
    logic [7:0] d;
    bit pe, pt, pb, sb, dv, perr, serr;
  } vec_t;
  logic clk = 1'b0;
  logic rst, rx_in, par_en, par_type, parity_error;
  logic samp_bit, par_chk_en, par_type_q, data_valid, par_err, stop_err, busy;
  logic [7:0] p_data;
  int tests = 0, fails = 0, t0 = 0;
  int cyc = 0, dv_n = 0, pce_n = 0, fall_cyc = 0;
  int dv_cyc_q[$];
  logic [7:0] dv_byte_q[$];
  logic prev_busy = 1'b0;
  vec_t tbl[8];

  uart_rx_ctrl #(.OVS(OVS)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .par_type    (par_type),
    .parity_error(parity_error),
    .samp_bit    (samp_bit),
    .p_data      (p_data),
    .par_chk_en  (par_chk_en),
    .par_type_q  (par_type_q),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stop_err    (stop_err),
    .busy        (busy)
  );

  // external combinational parity checker: error when data+bit parity disagrees with the latched type
  assign parity_error = ^p_data ^ samp_bit ^ par_type_q;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (data_valid) begin
      dv_n <= dv_n + 1;
      dv_cyc_q.push_back(cyc);
      dv_byte_q.push_back(p_data);
    end
    if (par_chk_en) pce_n <= pce_n + 1;
    if (prev_busy && !busy) fall_cyc <= cyc;
    prev_busy <= busy;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt, input bit pb, input bit sb, input bit scr);
    par_en = pe;
    par_type = pt;
    rx_in = 1'b0;
    t0 = cyc;
    step(OVS);
    if (scr) begin
      par_en = 1'($urandom);
      par_type = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      step(OVS);
    end
    if (pe) begin
      rx_in = pb;
      step(OVS);
    end
    rx_in = sb;
    step(OVS);
    rx_in = 1'b1;
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input bit pe, input bit pt, input bit pb,
                             input bit sb, input bit scr, input bit edv, input bit eperr, input bit eserr);
    int n0, p0, len;
    n0 = dv_n;
    p0 = pce_n;
    len = (10 + int'(pe)) * OVS;
    send_frame(d, pe, pt, pb, sb, scr);
    step(3);
    chk({name, " dv count"}, dv_n - n0, int'(edv));
    if (dv_n > n0) begin
      chk({name, " dv delay"}, dv_cyc_q[n0] - t0, len);
      chk({name, " dv byte"}, int'(dv_byte_q[n0]), int'(d));
    end
    chk({name, " p_data"}, int'(p_data), int'(d));
    chk({name, " par_chk_en cycles"}, pce_n - p0, int'(pe));
    chk({name, " par_err"}, int'(par_err), int'(eperr));
    chk({name, " stop_err"}, int'(stop_err), int'(eserr));
    chk({name, " par_type_q"}, int'(par_type_q), int'(pt));
    chk({name, " frame length"}, fall_cyc - t0, len);
    chk({name, " busy idle"}, int'(busy), 0);
  endtask

  initial begin
    int n0, t1;
    logic [7:0] d;
    bit pe, pt, pb, sb, eperr;
    rst = 1'b0;
    rx_in = 1'b1;
    par_en = 1'b0;
    par_type = 1'b0;
    step(3);
    chk("reset samp_bit", int'(samp_bit), 0);
    chk("reset p_data", int'(p_data), 0);
    chk("reset par_chk_en", int'(par_chk_en), 0);
    chk("reset par_type_q", int'(par_type_q), 0);
    chk("reset data_valid", int'(data_valid), 0);
    chk("reset par_err", int'(par_err), 0);
    chk("reset stop_err", int'(stop_err), 0);
    chk("reset busy", int'(busy), 0);
    rst = 1'b1;
    step(2);

    tbl[0] = '{8'hA5, 1, PAR_EVEN, 0, 1, 1, 0, 0};
    tbl[1] = '{8'hA5, 1, PAR_EVEN, 1, 1, 0, 1, 0};
    tbl[2] = '{8'hA5, 1, PAR_ODD,  1, 1, 1, 0, 0};
    tbl[3] = '{8'h3C, 0, PAR_EVEN, 0, 0, 0, 0, 1};
    tbl[4] = '{8'h00, 1, PAR_ODD,  0, 1, 0, 1, 0};
    tbl[5] = '{8'hFF, 0, PAR_ODD,  0, 1, 1, 0, 0};
    tbl[6] = '{8'h81, 1, PAR_EVEN, 0, 0, 0, 0, 1};
    tbl[7] = '{8'h6E, 1, PAR_EVEN, 0, 0, 0, 1, 1};
    for (int i = 0; i < 8; i++)
      check_frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].pb, tbl[i].sb, 1'b0,
                  tbl[i].dv, tbl[i].perr, tbl[i].serr);

    check_frame("pre-glitch", 8'h5A, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n0 = dv_n;
    rx_in = 1'b0;
    t0 = cyc;
    step(3);
    rx_in = 1'b1;
    step(OVS + 2);
    chk("glitch busy drop", fall_cyc - t0, OVS);
    chk("glitch no strobe", dv_n - n0, 0);
    chk("glitch par_err", int'(par_err), 0);
    chk("glitch stop_err", int'(stop_err), 0);
    chk("glitch p_data", int'(p_data), 8'h5A);
    chk("glitch busy", int'(busy), 0);

    n0 = dv_n;
    send_frame(8'h01, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0);
    t1 = t0;
    send_frame(8'hFE, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0);
    step(3);
    chk("b2b strobes", dv_n - n0, 2);
    if (dv_n >= n0 + 2) begin
      chk("b2b first delay", dv_cyc_q[n0] - t1, 11 * OVS);
      chk("b2b spacing", dv_cyc_q[n0+1] - dv_cyc_q[n0], 11 * OVS);
      chk("b2b byte0", int'(dv_byte_q[n0]), 8'h01);
      chk("b2b byte1", int'(dv_byte_q[n0+1]), 8'hFE);
    end

    n0 = dv_n;
    par_en = 1'b1;
    par_type = PAR_ODD;
    rx_in = 1'b0;
    step(OVS);
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b1;
      step(OVS);
    end
    step(5);
    #2 rst = 1'b0;
    #1;
    chk("mid rst samp_bit", int'(samp_bit), 0);
    chk("mid rst p_data", int'(p_data), 0);
    chk("mid rst par_chk_en", int'(par_chk_en), 0);
    chk("mid rst par_type_q", int'(par_type_q), 0);
    chk("mid rst data_valid", int'(data_valid), 0);
    chk("mid rst par_err", int'(par_err), 0);
    chk("mid rst stop_err", int'(stop_err), 0);
    chk("mid rst busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(OVS);
    chk("mid rst no strobe", dv_n - n0, 0);
    chk("mid rst idle", int'(busy), 0);
    check_frame("post-rst", 8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      pb = 1'($urandom);
      sb = $urandom_range(0, 3) != 0;
      eperr = pe && ((($countones(d) + int'(pb)) % 2) != int'(pt));
      check_frame($sformatf("rnd%0d", i), d, pe, pt, pb, sb, 1'b1, !eperr && sb, eperr, !sb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
